linear_synchronous_fifo: RTL and testbench
==========================================

LINEAR_SYNCHRONOUS_FIFO -- requirements
Module: linear_synchronous_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of storage locations (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-006 The block SHALL have port rd_en, input, 1 bit, read request.
REQ-007 The block SHALL have port data_in, input, DATA_WIDTH bits, write data.
REQ-008 The block SHALL have port data_out, output, DATA_WIDTH bits, registered read data.
REQ-009 The block SHALL have port full, output, 1 bit, high when no write can be accepted.
REQ-010 The block SHALL have port empty, output, 1 bit, high when no stored words remain.

Function
REQ-011 The block SHALL use a linear buffer: write pointer wr_ptr and read pointer rd_ptr, each clog2(DEPTH)+1 bits, that never wrap.
REQ-012 An accepted write SHALL store data_in at mem[wr_ptr] and increment wr_ptr; a write is accepted when wr_en=1 and full=0.
REQ-013 An accepted read SHALL load mem[rd_ptr] into data_out on the same edge and increment rd_ptr (1-cycle latency); a read is accepted when rd_en=1 and empty=0.
REQ-014 empty SHALL be combinational: (rd_ptr == wr_ptr).
REQ-015 full SHALL be combinational: (wr_ptr == DEPTH), regardless of rd_ptr; space freed by reads is not reusable until the buffer drains.
REQ-016 When an accepted read makes rd_ptr equal wr_ptr and no write is accepted that edge, both pointers SHALL collapse to 0 on that edge.
REQ-017 Write while full SHALL be ignored: no memory, pointer or flag change.
REQ-018 Read while empty SHALL be ignored: data_out holds its value and the pointers do not change.
REQ-019 With simultaneous wr_en and rd_en and neither flag blocking, both operations SHALL occur on the same edge; read returns the oldest word.
REQ-020 With simultaneous wr_en and rd_en while empty, only the write SHALL occur; while full, only the read SHALL occur.
REQ-021 data_out SHALL hold its last value whenever no read is accepted.
REQ-022 Words SHALL be returned in exact write order (FIFO).

Reset
REQ-023 reset=0 SHALL immediately, without waiting for clk, set wr_ptr=0, rd_ptr=0, data_out=0, giving empty=1 and full=0.
REQ-024 Memory contents SHALL NOT be reset; stale contents are unreachable after reset.
REQ-025 Reset asserted mid-operation SHALL discard all stored words; the first accepted write after release SHALL land at mem[0].

Configuration
REQ-026 Macro LINEAR_FIFO_ERR_FLAGS_EN defined: the block SHALL add 1-bit outputs overflow and underflow, reset to 0, set on the edge of a write-while-full or read-while-empty attempt respectively, and held sticky until reset.
REQ-027 Macro LINEAR_FIFO_ERR_FLAGS_EN undefined: those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Pulse reset low for 1 ns -> data_out=0, empty=1, full=0 immediately, before the next clock edge.
REQ-029 Write 1,2,3,4,5,6,7 on consecutive edges, then wr_en=0, rd_en=1 for 7 edges -> data_out=1..7 one per edge; empty=1 after the 7th read; full never asserted.
REQ-030 Write 8 words 1..8, then a 9th write of 9 -> full=1 after the 8th write; 9 discarded; 8 reads return 1..8; overflow=1 with LINEAR_FIFO_ERR_FLAGS_EN.
REQ-031 Write 8, read 3, then attempt write -> full stays 1 and the write is ignored; drain the remaining 5 -> pointers collapse, full=0, empty=1; next write of 5 then read -> data_out=5.
REQ-032 With 2 words stored, hold wr_en=rd_en=1 for 4 edges writing 10..13 -> outputs in order with no loss; empty and full never asserted.
REQ-033 Read on empty with data_out=7 -> data_out stays 7; underflow=1 with LINEAR_FIFO_ERR_FLAGS_EN; reset mid-fill with 3 words -> empty=1, and the next write/read returns the new word.

Source files
------------

// File: rtl/linear_synchronous_fifo.sv
// ---------------------------------------------------------------------------
// LinearSynchronousFifo (module linear_synchronous_fifo)
//
// Purpose:
//   Single-clock FIFO built on a linear (non-wrapping) buffer. Words are
//   written at wrPtr and read at rdPtr. Both pointers only count up. Space
//   freed by reads is reclaimed only when the buffer drains completely. At
//   that point both pointers collapse back to zero.
//
// Parameters:
//   DATA_WIDTH  word width in bits (default 4)
//   DEPTH       number of storage locations, power of two, >= 2 (default 8)
//
// Ports:
//   clk        in   single clock, all state changes on rising edge
//   reset      in   asynchronous, active-low reset
//   wr_en      in   write request
//   rd_en      in   read request
//   data_in    in   write data
//   data_out   out  registered read data (1-cycle latency)
//   full       out  no write can be accepted (wrPtr == DEPTH)
//   empty      out  no stored words remain (rdPtr == wrPtr)
//   overflow   out  sticky write-while-full flag   (LINEAR_FIFO_ERR_FLAGS_EN)
//   underflow  out  sticky read-while-empty flag   (LINEAR_FIFO_ERR_FLAGS_EN)
//
// Optional feature macro: LINEAR_FIFO_ERR_FLAGS_EN
//   Define it to add the sticky overflow/underflow outputs. Leave it
//   undefined to build the plain FIFO without those ports.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module linear_synchronous_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef LINEAR_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LIMIT = PTR_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;

  logic wrAccept;
  logic rdAccept;
  logic lastWordRead;

  // full looks only at wrPtr. Reads do not free space until the buffer
  // drains and the pointers collapse.
  assign full     = (wrPtr_q == PTR_LIMIT);
  assign empty    = (rdPtr_q == wrPtr_q);
  assign data_out = dataOut_q;

  assign wrAccept = wr_en && !full;
  assign rdAccept = rd_en && !empty;

  // This read takes the last stored word and no new word arrives on the
  // same edge. That is the only moment the buffer can rewind to location 0.
  assign lastWordRead = rdAccept && !wrAccept && ((rdPtr_q + PTR_ONE) == wrPtr_q);

  // Next-state for the pointers and the read data register.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    dataOut_d = dataOut_q;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (rdAccept) begin
      dataOut_d = mem[rdPtr_q[AW-1:0]];
      rdPtr_d   = rdPtr_q + PTR_ONE;
    end
    if (lastWordRead) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end
  end

  // Pointer and output registers. Reset clears them immediately, which
  // makes every stale word in memory unreachable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      dataOut_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      dataOut_q <= dataOut_d;
    end
  end

  // Storage is deliberately left out of reset.
  // wrPtr is below DEPTH whenever a write is accepted, so the low bits
  // index the array directly.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wrPtr_q[AW-1:0]] <= data_in;
    end
  end

`ifdef LINEAR_FIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags. Once set, they stay set until reset.
  assign overflow_d  = overflow_q  || (wr_en && full);
  assign underflow_d = underflow_q || (rd_en && empty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_linear_synchronous_fifo.sv
// ---------------------------------------------------------------------------
// tb_linear_synchronous_fifo
//
// Self-checking bench for linear_synchronous_fifo. A queue-based model
// tracks the FIFO contents and the number of writes since the last drain.
// Directed sequences pin known values. A long randomized run follows.
// Builds with or without LINEAR_FIFO_ERR_FLAGS_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_linear_synchronous_fifo;

  localparam int DW    = 4;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
`ifdef LINEAR_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  linear_synchronous_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
`ifdef LINEAR_FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model:
  // - modelQ holds the stored words, oldest first.
  // - wrCount counts the writes since the last drain. The buffer is full
  //   once DEPTH words have been written, no matter how many were read.
  logic [DW-1:0] modelQ[$];
  int            wrCount;
  logic [DW-1:0] expData;
  bit            expOvf;
  bit            expUnf;
  bit            mFull;
  bit            mEmpty;
  bit            mDoW;
  bit            mDoR;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      modelQ.delete();
      wrCount = 0;
      expData = '0;
      expOvf  = 0;
      expUnf  = 0;
    end else begin
      mFull  = (wrCount == DEPTH);
      mEmpty = (modelQ.size() == 0);
      mDoW   = wr_en && !mFull;
      mDoR   = rd_en && !mEmpty;
      if (wr_en && mFull)  expOvf = 1;
      if (rd_en && mEmpty) expUnf = 1;
      if (mDoR) expData = modelQ.pop_front();
      if (mDoW) begin
        modelQ.push_back(data_in);
        wrCount++;
      end
      if (mDoR && !mDoW && modelQ.size() == 0) wrCount = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmpData",  data_out, expData);
      checkOutput("cmpFull",  full,     (wrCount == DEPTH));
      checkOutput("cmpEmpty", empty,    (modelQ.size() == 0));
`ifdef LINEAR_FIFO_ERR_FLAGS_EN
      checkOutput("cmpOvf",   overflow,  expOvf);
      checkOutput("cmpUnf",   underflow, expUnf);
`endif
    end
  end

  // Drive one cycle of requests. Return 1 ns after the active edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges and check the state right away.
  task automatic pulseReset();
    @(negedge clk);
    wr_en = 0;
    rd_en = 0;
    #2 reset = 0;
    #0.5;
    checkOutput("rstData",  data_out, 0);
    checkOutput("rstEmpty", empty,    1);
    checkOutput("rstFull",  full,     0);
    #0.5 reset = 1;
  endtask

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: sim time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pw;
    logic [DW-1:0] expSeq[4];
    reset   = 1;
    wr_en   = 0;
    rd_en   = 0;
    data_in = '0;
    #2 reset = 0;
    #1;
    checkOutput("initData",  data_out, 0);
    checkOutput("initEmpty", empty,    1);
    checkOutput("initFull",  full,     0);
    #20 reset = 1;
    checkEn = 1;

    // Seven writes, then seven reads. The buffer never reaches full.
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1, 0, DW'(i));
      checkOutput("w7Full", full, 0);
    end
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(0, 1, '0);
      checkOutput("r7Data", data_out, i);
      checkOutput("r7Full", full, 0);
    end
    checkOutput("r7Empty", empty, 1);

    // Fill to DEPTH, then try a 9th write, which is dropped.
    for (int i = 1; i <= 8; i++) applyStimulus(1, 0, DW'(i));
    checkOutput("fill8Full", full, 1);
    applyStimulus(1, 0, 4'd9);
    checkOutput("ovfFull", full, 1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1, '0);
      checkOutput("r8Data", data_out, i);
    end
    checkOutput("r8Empty", empty, 1);
    checkOutput("r8Full",  full,  0);
`ifdef LINEAR_FIFO_ERR_FLAGS_EN
    checkOutput("overflowSet", overflow, 1);
`endif

    // Partial reads do not free space until the buffer drains.
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, DW'(8 + i));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, '0);
      checkOutput("part3Data", data_out, 8 + i);
    end
    checkOutput("partFull", full, 1);
    applyStimulus(1, 0, 4'd0);
    checkOutput("partFull2", full, 1);
    for (int i = 3; i < 8; i++) begin
      applyStimulus(0, 1, '0);
      checkOutput("drainData", data_out, 8 + i);
    end
    checkOutput("drainFull",  full,  0);
    checkOutput("drainEmpty", empty, 1);
    applyStimulus(1, 0, 4'd5);
    applyStimulus(0, 1, '0);
    checkOutput("after5Data", data_out, 5);

    // Simultaneous read and write with two words already stored.
    applyStimulus(1, 0, 4'd1);
    applyStimulus(1, 0, 4'd2);
    expSeq[0] = 4'd1;
    expSeq[1] = 4'd2;
    expSeq[2] = 4'd10;
    expSeq[3] = 4'd11;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, DW'(10 + i));
      checkOutput("rwData",  data_out, expSeq[i]);
      checkOutput("rwEmpty", empty, 0);
      checkOutput("rwFull",  full,  0);
    end
    applyStimulus(0, 1, '0);
    checkOutput("rwTail0", data_out, 12);
    applyStimulus(0, 1, '0);
    checkOutput("rwTail1", data_out, 13);
    checkOutput("rwEmpty2", empty, 1);

    // A read on an empty buffer holds data_out.
    applyStimulus(1, 0, 4'd7);
    applyStimulus(0, 1, '0);
    checkOutput("hold7a", data_out, 7);
    applyStimulus(0, 1, '0);
    checkOutput("hold7b", data_out, 7);
`ifdef LINEAR_FIFO_ERR_FLAGS_EN
    checkOutput("underflowSet", underflow, 1);
`endif

    // Reset partway through a fill, then check that the next word comes
    // back by itself.
    for (int i = 1; i <= 3; i++) applyStimulus(1, 0, DW'(i));
    pulseReset();
    checkOutput("midRstEmpty", empty, 1);
    applyStimulus(1, 0, 4'hA);
    applyStimulus(0, 1, '0);
    checkOutput("midRstData", data_out, 4'hA);
    applyStimulus(0, 0, '0);

    // Randomized traffic. Fill-biased and drain-biased phases alternate
    // so that full and the collapse are both reached often.
    for (int c = 0; c < 2000; c++) begin
      pw = ((c / 100) % 2 == 0) ? 80 : 25;
      if ($urandom_range(0, 399) == 0) begin
        pulseReset();
      end else begin
        applyStimulus(($urandom_range(0, 99) < pw),
                      ($urandom_range(0, 99) < (100 - pw)),
                      DW'($urandom));
      end
    end
    applyStimulus(0, 0, '0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
